// File: rtl/fp16_accum_pkg.sv
// rtl/fp16_accum_pkg.sv - shared types and constants for the fp16 accumulator feeder
package fp16_accum_pkg;

    typedef logic [15:0] fp16_t;

    localparam fp16_t FP16_ZERO = 16'h0000;
    localparam fp16_t FP16_QNAN = 16'h7E00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_FLUSH_WAIT,
        ST_READ,
        ST_SEND,
        ST_GAP,
        ST_WAIT_RES,
        ST_DONE
    } feeder_state_t;

endpackage

// File: rtl/fp16_accum_feeder_if.sv
// rtl/fp16_accum_feeder_if.sv - control, BRAM, stream and result signals of the feeder
interface fp16_accum_feeder_if #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 10
);
    import fp16_accum_pkg::*;

    logic              start;
    logic              flush_en;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  length;
    logic              busy;
    logic              done;
    logic              timeout;
    fp16_t             result;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    fp16_t             mem_rdata;
    logic              m_axis_tvalid;
    fp16_t             m_axis_tdata;
    logic              m_axis_tlast;
    logic              s_result_tvalid;
    fp16_t             s_result_tdata;
    logic              s_result_tlast;

    // feeder side
    modport master (
        input  start, flush_en, base_addr, length, mem_rdata,
               s_result_tvalid, s_result_tdata, s_result_tlast,
        output busy, done, timeout, result, mem_rd, mem_addr,
               m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    // environment side (host, BRAM, accumulator IP)
    modport slave (
        output start, flush_en, base_addr, length, mem_rdata,
               s_result_tvalid, s_result_tdata, s_result_tlast,
        input  busy, done, timeout, result, mem_rd, mem_addr,
               m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

endinterface

// File: rtl/fp16_accum_feeder.sv
// rtl/fp16_accum_feeder.sv - streams a BRAM vector into a tready-less fp16 accumulator and returns its sum
module fp16_accum_feeder
    import fp16_accum_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 1023
) (
    input logic                    clk,
    input logic                    reset,
    fp16_accum_feeder_if.master    bus
);

    // one down-counter is shared by beat pacing and the result timeout
    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [LEN_W-1:0] IDX_ONE = 1;

    feeder_state_t      state;
    logic [ADDR_W-1:0]  base_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    fp16_t              result_q;
    logic               busy_q;
    logic               done_q;
    logic               timeout_q;
    logic               rd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               tvalid_q;
    logic               tlast_q;
    logic               res_last;

    // only tlast-tagged results are final sums; partial sums never matter
    assign res_last = bus.s_result_tvalid & bus.s_result_tlast;

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.timeout       = timeout_q;
    assign bus.result        = result_q;
    assign bus.mem_rd        = rd_q;
    assign bus.mem_addr      = addr_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    // BRAM data arrives in the SEND cycle, so it is forwarded rather than registered
    assign bus.m_axis_tdata  = (state == ST_SEND) ? bus.mem_rdata : FP16_ZERO;

    // job sequencer: read/send/gap per element, then wait for the final sum
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            base_q    <= '0;
            len_q     <= '0;
            idx       <= '0;
            cnt       <= '0;
            result_q  <= FP16_ZERO;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
        end else begin
            rd_q     <= 1'b0;
            addr_q   <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        base_q    <= bus.base_addr;
                        len_q     <= bus.length;
                        idx       <= '0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (bus.flush_en) begin
                            state    <= ST_FLUSH;
                            tvalid_q <= 1'b1;
                            tlast_q  <= 1'b1;
                        end else if (bus.length == '0) begin
                            state    <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= FP16_ZERO;
                        end else begin
                            state  <= ST_READ;
                            rd_q   <= 1'b1;
                            addr_q <= bus.base_addr;
                        end
                    end
                end
                ST_FLUSH: begin
                    state <= ST_FLUSH_WAIT;
                    cnt   <= CNT_W'(TIMEOUT - 1);
                end
                ST_FLUSH_WAIT: begin
                    // the flushed stale sum is consumed here and thrown away
                    if (res_last) begin
                        if (len_q == '0) begin
                            state    <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= FP16_ZERO;
                        end else begin
                            state  <= ST_READ;
                            rd_q   <= 1'b1;
                            addr_q <= base_q;
                        end
                    end else if (cnt == '0) begin
                        state     <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        result_q  <= FP16_QNAN;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_READ: begin
                    state    <= ST_SEND;
                    tvalid_q <= 1'b1;
                    tlast_q  <= (idx == len_q - IDX_ONE);
                end
                ST_SEND: begin
                    if (tlast_q) begin
                        state <= ST_WAIT_RES;
                        cnt   <= CNT_W'(TIMEOUT - 1);
                    end else begin
                        idx <= idx + IDX_ONE;
                        if (GAP_CYCLES > 0) begin
                            state <= ST_GAP;
                            cnt   <= CNT_W'(GAP_CYCLES - 1);
                        end else begin
                            state  <= ST_READ;
                            rd_q   <= 1'b1;
                            addr_q <= base_q + ADDR_W'(idx + IDX_ONE);
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state  <= ST_READ;
                        rd_q   <= 1'b1;
                        addr_q <= base_q + ADDR_W'(idx);
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_last) begin
                        state    <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= bus.s_result_tdata;
                    end else if (cnt == '0) begin
                        state     <= ST_DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                        result_q  <= FP16_QNAN;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_accum_feeder.sv
// tb/tb_fp16_accum_feeder.sv - scoreboard bench with BRAM and accumulator IP models
module tb_fp16_accum_feeder;

    localparam int GAP = 1;
    localparam int TMO = 40;
    localparam int LAT = 12;

    typedef struct { logic [15:0] data; logic last; int cyc; } beat_t;
    typedef struct { logic [15:0] res; logic to; int cyc; } res_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   beat_cnt = 0;
    int   done_cnt = 0;
    logic [15:0] last_res = 16'h0;
    bit   mon_en = 0;
    bit   withhold = 0;

    beat_t beat_q[$];
    int    addr_q[$];
    res_t  res_q[$];

    logic [15:0] mem [1024];
    logic [15:0] bram_q = 16'h0;
    int          acc = 0;
    logic [LAT-1:0]    pv = '0;
    logic [LAT-1:0]    pl = '0;
    logic [LAT*16-1:0] pd = '0;

    fp16_accum_feeder_if #(.ADDR_W(10), .LEN_W(10)) bus ();

    fp16_accum_feeder #(
        .ADDR_W(10), .LEN_W(10), .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] int_to_fp16(input int n);
        int e;
        int m;
        if (n <= 0) return 16'h0000;
        e = 0;
        for (int i = 0; i < 11; i++) if (((n >> i) & 1) != 0) e = i;
        m = (n << (10 - e)) & 'h3FF;
        return {1'b0, 5'(e + 15), 10'(m)};
    endfunction

    function automatic int fp16_to_int(input logic [15:0] h);
        int e;
        int m;
        if (h[14:0] == 15'h0) return 0;
        e = int'(h[14:10]) - 15;
        m = 1024 + int'(h[9:0]);
        return m >> (10 - e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // BRAM: one-cycle read latency
    always @(posedge clk) if (bus.mem_rd) bram_q <= mem[bus.mem_addr];
    assign bus.mem_rdata = bram_q;

    // accumulator IP: running integer sum, every beat answered LAT cycles later, tlast clears
    always @(posedge clk) begin
        int nsum;
        nsum = acc + fp16_to_int(bus.m_axis_tdata);
        pv <= {pv[LAT-2:0], bus.m_axis_tvalid && !(bus.m_axis_tlast && withhold)};
        pl <= {pl[LAT-2:0], bus.m_axis_tlast};
        pd <= {pd[(LAT-1)*16-1:0], int_to_fp16(nsum)};
        if (bus.m_axis_tvalid) acc <= bus.m_axis_tlast ? 0 : nsum;
    end
    assign bus.s_result_tvalid = pv[LAT-1];
    assign bus.s_result_tlast  = pv[LAT-1] & pl[LAT-1];
    assign bus.s_result_tdata  = pd[LAT*16-1 -: 16];

    // monitor: pops expectations whenever the DUT presents a beat, a read or a done
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.m_axis_tvalid) begin
                beat_cnt++;
                if (beat_q.size() == 0) check("unexpected_beat", 1, 0);
                else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    check("beat_data", 32'(bus.m_axis_tdata), 32'(b.data));
                    check("beat_last", 32'(bus.m_axis_tlast), 32'(b.last));
                    if (b.cyc >= 0) check("beat_cycle", cyc, b.cyc);
                end
            end else begin
                check("idle_stream", {15'h0, bus.m_axis_tlast, bus.m_axis_tdata}, 0);
            end
            if (bus.mem_rd) begin
                if (addr_q.size() == 0) check("unexpected_read", 1, 0);
                else check("mem_addr", 32'(bus.mem_addr), addr_q.pop_front());
            end
            if (bus.done) begin
                done_cnt++;
                last_res = bus.result;
                if (res_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    res_t r;
                    r = res_q.pop_front();
                    check("result", 32'(bus.result), 32'(r.res));
                    check("timeout_flag", 32'(bus.timeout), 32'(r.to));
                    if (r.cyc >= 0) check("done_cycle", cyc, r.cyc);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!bus.busy) return;
        end
        check("idle_wait_expired", 0, 1);
    endtask

    task automatic wait_done(input int prev, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_cnt != prev) return;
        end
        check("done_wait_expired", 0, 1);
    endtask

    // drive one start and queue what the job must produce
    task automatic issue_job(input int base, input int len, input bit flush, input bit hold2, input bit wh);
        int t0;
        int sum;
        int a;
        res_t r;
        wait_idle();
        withhold = wh;
        bus.start = 1'b1;
        bus.flush_en = flush;
        bus.base_addr = 10'(base);
        bus.length = 10'(len);
        t0 = cyc;
        sum = 0;
        if (flush) beat_q.push_back('{16'h0000, 1'b1, t0 + 1});
        for (int i = 0; i < len; i++) begin
            a = (base + i) % 1024;
            addr_q.push_back(a);
            sum += fp16_to_int(mem[a]);
            beat_q.push_back('{mem[a], (i == len - 1), flush ? -1 : t0 + 2 + i * (2 + GAP)});
        end
        r.to  = wh;
        r.res = wh ? 16'h7E00 : int_to_fp16(sum);
        if (len == 0 && !flush) r.cyc = t0 + 1;
        else if (wh && !flush) r.cyc = t0 + 2 + (len - 1) * (2 + GAP) + 1 + TMO;
        else r.cyc = -1;
        res_q.push_back(r);
        @(negedge clk);
        check("busy_after_start", 32'(bus.busy), 1);
        check("timeout_cleared", 32'(bus.timeout), 0);
        if (hold2) begin
            @(negedge clk);
            check("busy_after_done", 32'(bus.busy), 0);
        end
        bus.start = 1'b0;
    endtask

    task automatic run_job(input int base, input int len, input bit flush, input bit hold2, input bit wh);
        int dc;
        dc = done_cnt;
        issue_job(base, len, flush, hold2, wh);
        if (done_cnt == dc) wait_done(dc, TMO + 400);
        repeat (4) @(negedge clk);
        withhold = 0;
        check("done_count", done_cnt - dc, 1);
        check("beats_left", beat_q.size(), 0);
        check("reads_left", addr_q.size(), 0);
    endtask

    initial begin
        int bc;
        int dc;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.flush_en = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        for (int i = 0; i < 1024; i++) mem[i] = int_to_fp16($urandom_range(0, 31));
        mem[0] = 16'h3C00;
        mem[1] = 16'h4000;
        mem[2] = 16'h4200;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_timeout", 32'(bus.timeout), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_mem_rd", 32'(bus.mem_rd), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_tvalid", 32'(bus.m_axis_tvalid), 0);
        check("rst_tdata", 32'(bus.m_axis_tdata), 0);
        check("rst_tlast", 32'(bus.m_axis_tlast), 0);
        reset = 1'b0;
        mon_en = 1;
        @(negedge clk);

        // 1.0 + 2.0 + 3.0, plain then with flush
        run_job(0, 3, 0, 0, 0);
        check("t1_result", 32'(last_res), 32'h4600);
        run_job(0, 3, 1, 0, 0);
        check("t2_result", 32'(last_res), 32'h4600);

        // empty vector, start held into the DONE cycle
        run_job(7, 0, 0, 1, 0);
        check("t3_result", 32'(last_res), 32'h0000);

        // accumulator never answers
        run_job(20, 1, 0, 0, 1);
        check("t4_timeout_sticky", 32'(bus.timeout), 1);
        check("t4_result", 32'(last_res), 32'h7E00);

        // reset after the second beat of a five-element job
        bc = beat_cnt;
        issue_job(100, 5, 0, 0, 0);
        for (int i = 0; i < 40 && beat_cnt < bc + 2; i++) @(negedge clk);
        check("t5_two_beats", beat_cnt - bc, 2);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tvalid", 32'(bus.m_axis_tvalid), 0);
        check("t5_tdata", 32'(bus.m_axis_tdata), 0);
        check("t5_mem_rd", 32'(bus.mem_rd), 0);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        reset = 1'b0;
        beat_q.delete();
        addr_q.delete();
        res_q.delete();
        dc = done_cnt;
        repeat (30) @(negedge clk);
        check("t5_no_done", done_cnt, dc);
        run_job(0, 3, 1, 0, 0);
        check("t5_result", 32'(last_res), 32'h4600);

        // start while busy is ignored; address wraps past 3FF
        dc = done_cnt;
        issue_job(1023, 2, 0, 0, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush_en = 1'b1;
        bus.base_addr = 10'd5;
        bus.length = 10'd4;
        @(negedge clk);
        bus.start = 1'b0;
        if (done_cnt == dc) wait_done(dc, 400);
        repeat (20) @(negedge clk);
        check("t6_done_count", done_cnt - dc, 1);
        check("t6_beats_left", beat_q.size(), 0);
        check("t6_reads_left", addr_q.size(), 0);

        // random jobs
        for (int j = 0; j < 20; j++)
            run_job($urandom_range(0, 1023), $urandom_range(0, 6), 1'($urandom_range(0, 1)), 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
